// File: rtl/neuron_layer_scheduler.sv
// neuron_layer_scheduler
// Time-multiplexes one shared full_neuron datapath over NUM_NEURONS logical
// neurons. A per-neuron weight/bias bank is written through a config port
// while idle. One 4-element input vector is accepted per layer pass. The
// shared neuron is then evaluated once per logical neuron, and each
// registered result is streamed out under valid/ready back-pressure.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input vector handshake
//   in_x0..in_x3          input vector elements (8b)
//   cfg_we/addr/sel/data  bank write: sel 0..3 = w0..w3, 4 = bias
//   cfg_err               one-cycle pulse after a dropped config write
//   nx*/nw*/nbias         operands driven to the shared full_neuron
//   neuron_result         combinational full_neuron output (18b)
//   out_valid/out_ready   result handshake
//   out_data/out_idx      registered result and its logical neuron index
//   out_last              result belongs to neuron NUM_NEURONS-1
//   layer_done            one-cycle pulse after the last result is taken
module neuron_layer_scheduler #(
    parameter  int NUM_NEURONS = 4,
    localparam int IDX_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_x0,
    input  logic [7:0]       in_x1,
    input  logic [7:0]       in_x2,
    input  logic [7:0]       in_x3,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_addr,
    input  logic [2:0]       cfg_sel,
    input  logic [7:0]       cfg_data,
    output logic             cfg_err,
    output logic [7:0]       nx0,
    output logic [7:0]       nx1,
    output logic [7:0]       nx2,
    output logic [7:0]       nx3,
    output logic [7:0]       nw0,
    output logic [7:0]       nw1,
    output logic [7:0]       nw2,
    output logic [7:0]       nw3,
    output logic [7:0]       nbias,
    input  logic [17:0]      neuron_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [17:0]      out_data,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             layer_done
);

    typedef enum logic [1:0] {IDLE, RUN, EMIT} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);
    // One bit wider than an index so NUM_NEURONS itself is representable.
    localparam logic [IDX_W:0]   NUM_N    = (IDX_W + 1)'(NUM_NEURONS);

    state_t                              state;
    logic [IDX_W-1:0]                    idx;
    logic [3:0][7:0]                     x_lat;
    // Per neuron: entries 0..3 are w0..w3, entry 4 is the bias.
    logic [NUM_NEURONS-1:0][4:0][7:0]    bank;
    logic [4:0][7:0]                     cur;
    logic                                cfg_ok;

    // Select the bank entry of the neuron currently being scheduled. A
    // compare-based mux keeps non-power-of-two NUM_NEURONS free of
    // out-of-range reads.
    always_comb begin
        cur = '0;
        for (int n = 0; n < NUM_NEURONS; n++) begin
            if (idx == IDX_W'(n)) cur = bank[n];
        end
    end

    assign nx0   = x_lat[0];
    assign nx1   = x_lat[1];
    assign nx2   = x_lat[2];
    assign nx3   = x_lat[3];
    assign nw0   = cur[0];
    assign nw1   = cur[1];
    assign nw2   = cur[2];
    assign nw3   = cur[3];
    assign nbias = cur[4];

    // The bank only changes while idle, so a pass always sees one
    // consistent set of weights.
    assign cfg_ok = (state == IDLE) && ({1'b0, cfg_addr} < NUM_N) && (cfg_sel <= 3'd4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            x_lat      <= '0;
            bank       <= '0;
            out_data   <= '0;
            out_idx    <= '0;
            out_last   <= 1'b0;
            out_valid  <= 1'b0;
            cfg_err    <= 1'b0;
            layer_done <= 1'b0;
            in_ready   <= 1'b1;
        end else begin
            cfg_err    <= 1'b0;
            layer_done <= 1'b0;

            if (cfg_we) begin
                if (cfg_ok) begin
                    for (int n = 0; n < NUM_NEURONS; n++) begin
                        for (int s = 0; s < 5; s++) begin
                            if (cfg_addr == IDX_W'(n) && cfg_sel == 3'(s))
                                bank[n][s] <= cfg_data;
                        end
                    end
                end else begin
                    cfg_err <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        x_lat    <= {in_x3, in_x2, in_x1, in_x0};
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    // Operands were stable for the whole cycle; capture the
                    // shared neuron's answer for this logical neuron.
                    out_data  <= neuron_result;
                    out_idx   <= idx;
                    out_last  <= (idx == LAST_IDX);
                    out_valid <= 1'b1;
                    state     <= EMIT;
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            layer_done <= 1'b1;
                            in_ready   <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= RUN;
                        end
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_layer_scheduler.sv
// Directed bench for neuron_layer_scheduler. Three builds share one clock:
// A (4 neurons) for the main flow, B (3 neurons) for the out-of-range
// address drop, C (1 neuron) for the degenerate single-neuron layer. The
// shared full_neuron is modelled as sum(x*w) + bias.
module tb_neuron_layer_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [7:0]  x0, x1, x2, x3;
    logic [2:0]  cfg_sel;
    logic [7:0]  cfg_data;

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    function automatic logic [17:0] nmodel(input logic [7:0] a0, a1, a2, a3,
                                           input logic [7:0] w0, w1, w2, w3, b);
        return 18'(a0 * w0) + 18'(a1 * w1) + 18'(a2 * w2) + 18'(a3 * w3) + 18'(b);
    endfunction

    // ---------------- instance A: 4 neurons ----------------
    logic        iv_a, ir_a, we_a, err_a, ov_a, or_a, ol_a, ld_a;
    logic [1:0]  addr_a, oi_a;
    logic [7:0]  nxa0, nxa1, nxa2, nxa3, nwa0, nwa1, nwa2, nwa3, nba;
    logic [17:0] res_a, od_a;
    assign res_a = nmodel(nxa0, nxa1, nxa2, nxa3, nwa0, nwa1, nwa2, nwa3, nba);

    neuron_layer_scheduler #(.NUM_NEURONS(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_a), .in_ready(ir_a),
        .in_x0(x0), .in_x1(x1), .in_x2(x2), .in_x3(x3),
        .cfg_we(we_a), .cfg_addr(addr_a), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .cfg_err(err_a),
        .nx0(nxa0), .nx1(nxa1), .nx2(nxa2), .nx3(nxa3),
        .nw0(nwa0), .nw1(nwa1), .nw2(nwa2), .nw3(nwa3), .nbias(nba),
        .neuron_result(res_a), .out_valid(ov_a), .out_ready(or_a),
        .out_data(od_a), .out_idx(oi_a), .out_last(ol_a), .layer_done(ld_a)
    );

    // ---------------- instance B: 3 neurons ----------------
    logic        iv_b, ir_b, we_b, err_b, ov_b, or_b, ol_b, ld_b;
    logic [1:0]  addr_b, oi_b;
    logic [7:0]  nxb0, nxb1, nxb2, nxb3, nwb0, nwb1, nwb2, nwb3, nbb;
    logic [17:0] res_b, od_b;
    assign res_b = nmodel(nxb0, nxb1, nxb2, nxb3, nwb0, nwb1, nwb2, nwb3, nbb);

    neuron_layer_scheduler #(.NUM_NEURONS(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_b), .in_ready(ir_b),
        .in_x0(x0), .in_x1(x1), .in_x2(x2), .in_x3(x3),
        .cfg_we(we_b), .cfg_addr(addr_b), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .cfg_err(err_b),
        .nx0(nxb0), .nx1(nxb1), .nx2(nxb2), .nx3(nxb3),
        .nw0(nwb0), .nw1(nwb1), .nw2(nwb2), .nw3(nwb3), .nbias(nbb),
        .neuron_result(res_b), .out_valid(ov_b), .out_ready(or_b),
        .out_data(od_b), .out_idx(oi_b), .out_last(ol_b), .layer_done(ld_b)
    );

    // ---------------- instance C: 1 neuron ----------------
    logic        iv_c, ir_c, we_c, err_c, ov_c, or_c, ol_c, ld_c;
    logic [0:0]  addr_c, oi_c;
    logic [7:0]  nxc0, nxc1, nxc2, nxc3, nwc0, nwc1, nwc2, nwc3, nbc;
    logic [17:0] res_c, od_c;
    assign res_c = nmodel(nxc0, nxc1, nxc2, nxc3, nwc0, nwc1, nwc2, nwc3, nbc);

    neuron_layer_scheduler #(.NUM_NEURONS(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_c), .in_ready(ir_c),
        .in_x0(x0), .in_x1(x1), .in_x2(x2), .in_x3(x3),
        .cfg_we(we_c), .cfg_addr(addr_c), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .cfg_err(err_c),
        .nx0(nxc0), .nx1(nxc1), .nx2(nxc2), .nx3(nxc3),
        .nw0(nwc0), .nw1(nwc1), .nw2(nwc2), .nw3(nwc3), .nbias(nbc),
        .neuron_result(res_c), .out_valid(ov_c), .out_ready(or_c),
        .out_data(od_c), .out_idx(oi_c), .out_last(ol_c), .layer_done(ld_c)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // Config write on A; called and returns just after a falling edge.
    task automatic cfg_a(input logic [1:0] addr, input logic [2:0] sel,
                         input logic [7:0] data, input logic exp_err);
        we_a = 1'b1; addr_a = addr; cfg_sel = sel; cfg_data = data;
        @(negedge clk);
        chk("cfg_err", 32'(err_a), 32'(exp_err));
        we_a = 1'b0;
        @(negedge clk);
        chk("cfg_err_clr", 32'(err_a), 0);
    endtask

    task automatic load_a(input logic [7:0] w, input logic bias_is_idx);
        for (int k = 0; k < 4; k++) begin
            for (int s = 0; s < 4; s++) cfg_a(2'(k), 3'(s), w, 1'b0);
            cfg_a(2'(k), 3'd4, bias_is_idx ? 8'(k) : 8'd0, 1'b0);
        end
    endtask

    // One layer pass on A. Optional stall on one neuron, optional illegal
    // config write injected while the scheduler is in RUN.
    task automatic pass_a(input logic [7:0] a, b, c, d,
                          input logic [17:0] e0, e1, e2, e3,
                          input int stall_idx, input int stall_n, input bit inject);
        logic [17:0] ex[4];
        int t;
        int unsigned c0;
        ex = '{e0, e1, e2, e3};
        chk("in_ready_idle", 32'(ir_a), 1);
        x0 = a; x1 = b; x2 = c; x3 = d; iv_a = 1'b1; or_a = 1'b1;
        @(negedge clk);
        c0 = cyc;
        iv_a = 1'b0;
        chk("in_ready_run", 32'(ir_a), 0);
        if (inject) begin
            we_a = 1'b1; addr_a = 2'd0; cfg_sel = 3'd0; cfg_data = 8'h55;
        end
        for (int k = 0; k < 4; k++) begin
            t = 0;
            while (!ov_a && t < 10) begin @(negedge clk); t++; end
            chk("out_valid", 32'(ov_a), 1);
            chk("out_data", 32'(od_a), 32'(ex[k]));
            chk("out_idx", 32'(oi_a), k);
            chk("out_last", 32'(ol_a), (k == 3) ? 1 : 0);
            if (inject && k == 0) begin
                chk("cfg_err_run", 32'(err_a), 1);
                we_a = 1'b0;
            end
            if (k == stall_idx) begin
                or_a = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    @(negedge clk);
                    chk("stall_valid", 32'(ov_a), 1);
                    chk("stall_data", 32'(od_a), 32'(ex[k]));
                    chk("stall_idx", 32'(oi_a), k);
                end
                or_a = 1'b1;
            end
            @(negedge clk);
            if (inject && k == 0) chk("cfg_err_pulse", 32'(err_a), 0);
            chk("valid_drop", 32'(ov_a), 0);
        end
        chk("layer_done", 32'(ld_a), 1);
        if (stall_n == 0) chk("layer_cycles", cyc - c0, 8);
        @(negedge clk);
        chk("layer_done_pulse", 32'(ld_a), 0);
        chk("in_ready_back", 32'(ir_a), 1);
    endtask

    initial begin
        logic [17:0] got[$];
        int t, acc;
        rst_n = 1'b0;
        {x0, x1, x2, x3} = '0; cfg_sel = '0; cfg_data = '0;
        {iv_a, we_a, or_a, addr_a} = '0;
        {iv_b, we_b, or_b, addr_b} = '0;
        {iv_c, we_c, or_c, addr_c} = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(ir_a), 1);
        chk("rst_out_valid", 32'(ov_a), 0);
        chk("rst_out_data", 32'(od_a), 0);
        chk("rst_cfg_err", 32'(err_a), 0);
        chk("rst_layer_done", 32'(ld_a), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Neuron k: weights 1, bias k; x=(1,2,3,4) -> 10+k.
        load_a(8'd1, 1'b1);
        pass_a(1, 2, 3, 4, 10, 11, 12, 13, -1, 0, 1'b0);
        pass_a(1, 2, 3, 4, 10, 11, 12, 13, 2, 5, 1'b0);
        // Write during RUN is dropped; results unchanged.
        pass_a(1, 2, 3, 4, 10, 11, 12, 13, -1, 0, 1'b1);
        // Invalid selector is dropped.
        cfg_a(2'd0, 3'd6, 8'h55, 1'b1);
        pass_a(1, 2, 3, 4, 10, 11, 12, 13, -1, 0, 1'b0);

        // Reset while a result is waiting in EMIT.
        x0 = 1; x1 = 2; x2 = 3; x3 = 4; iv_a = 1'b1; or_a = 1'b0;
        @(negedge clk);
        iv_a = 1'b0;
        t = 0;
        while (!ov_a && t < 10) begin @(negedge clk); t++; end
        chk("pre_rst_valid", 32'(ov_a), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(ov_a), 0);
        chk("mid_rst_ready", 32'(ir_a), 1);
        chk("mid_rst_data", 32'(od_a), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pass_a(1, 2, 3, 4, 0, 0, 0, 0, -1, 0, 1'b0);

        // in_valid held high across two vectors; weights 1, bias 0.
        load_a(8'd1, 1'b0);
        x0 = 1; x1 = 1; x2 = 1; x3 = 1; iv_a = 1'b1; or_a = 1'b1;
        acc = 0; t = 0;
        while (got.size() < 8 && t < 60) begin
            if (ov_a) begin
                got.push_back(od_a);
                chk("busy_in_ready", 32'(ir_a), 0);
            end
            if (ir_a) begin
                acc++;
                if (acc == 2) chk("second_accept_at", 32'(got.size()), 4);
            end else if (acc == 1) begin
                x0 = 2; x1 = 2; x2 = 2; x3 = 2;
            end
            if (got.size() == 8) iv_a = 1'b0;
            @(negedge clk);
            t++;
        end
        iv_a = 1'b0;
        chk("held_count", 32'(got.size()), 8);
        chk("held_accepts", 32'(acc), 2);
        for (int i = 0; i < 8 && i < got.size(); i++)
            chk("held_result", 32'(got[i]), (i < 4) ? 4 : 8);
        repeat (3) @(negedge clk);
        chk("held_idle", 32'(ir_a), 1);

        // 3-neuron build: address 3 out of range, address 2 valid.
        we_b = 1'b1; addr_b = 2'd3; cfg_sel = 3'd0; cfg_data = 8'd7;
        @(negedge clk);
        chk("b_addr_err", 32'(err_b), 1);
        addr_b = 2'd2;
        @(negedge clk);
        chk("b_addr_ok", 32'(err_b), 0);
        we_b = 1'b0;

        // 1-neuron build: w0=3, x=(5,0,0,0) -> 15.
        we_c = 1'b1; addr_c = 1'b0; cfg_sel = 3'd0; cfg_data = 8'd3;
        @(negedge clk);
        chk("c_cfg_err", 32'(err_c), 0);
        we_c = 1'b0;
        x0 = 5; x1 = 0; x2 = 0; x3 = 0; iv_c = 1'b1; or_c = 1'b1;
        @(negedge clk);
        iv_c = 1'b0;
        t = 0;
        while (!ov_c && t < 10) begin @(negedge clk); t++; end
        chk("c_valid", 32'(ov_c), 1);
        chk("c_data", 32'(od_c), 15);
        chk("c_last", 32'(ol_c), 1);
        chk("c_idx", 32'(oi_c), 0);
        @(negedge clk);
        chk("c_layer_done", 32'(ld_c), 1);
        chk("c_valid_drop", 32'(ov_c), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
